// File: rtl/ctrl_pkg.sv
// ctrl_pkg: sequencer state encoding, RV32I base opcodes and opcode legality check.
package ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } seq_state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   function automatic logic is_legal_op(input logic [6:0] o);
      return o inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
                       OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM};
   endfunction
endpackage

// File: rtl/perf_counters.sv
// perf_counters: active-cycle and retired-instruction counters, wrapping.
module perf_counters #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  active,
   input  logic                  retire,
   output logic [DATA_WIDTH-1:0] cycle_cnt,
   output logic [DATA_WIDTH-1:0] instret
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         instret   <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + DATA_WIDTH'(active);
         instret   <= instret + DATA_WIDTH'(retire);
      end
   end
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle fetch/decode/exec/mem/wb sequencer for the RV32I core.
// Define PERF_CNT_EN to add the cycle_cnt/instret performance counters.
module mc_sequencer
   import ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [6:0] op,
   input  logic       cu_regwrite,
   input  logic       cu_memwrite,
   input  logic       cu_resultsrc,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_isfetch,
   output logic       ir_we,
   output logic       pc_we,
   output logic       rf_we,
   output logic       halted,
   output logic [2:0] state
`ifdef PERF_CNT_EN
   ,
   output logic [DATA_WIDTH-1:0] cycle_cnt,
   output logic [DATA_WIDTH-1:0] instret
`endif
);
   seq_state_t cur;
   seq_state_t eoi;
   logic       is_mem;

   assign eoi    = run ? S_FETCH : S_IDLE;
   assign is_mem = (op == OP_LOAD) || (op == OP_STORE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur <= S_IDLE;
      else begin
         case (cur)
            S_IDLE:   if (run) cur <= S_FETCH;
            S_FETCH:  if (mem_ack) cur <= S_DECODE;
            S_DECODE: cur <= (op == OP_SYSTEM || !is_legal_op(op)) ? S_HALT : S_EXEC;
            S_EXEC:   cur <= is_mem ? S_MEM : cu_regwrite ? S_WB : eoi;
            S_MEM:    if (mem_ack) cur <= cu_resultsrc ? S_WB : eoi;
            S_WB:     cur <= eoi;
            default:  cur <= S_HALT;
         endcase
      end
   end

   // Strobes decode straight from state so reset kills an open request at once.
   assign state       = cur;
   assign mem_req     = (cur == S_FETCH) || (cur == S_MEM);
   assign mem_isfetch = cur == S_FETCH;
   assign mem_we      = (cur == S_MEM) && cu_memwrite;
   assign ir_we       = (cur == S_FETCH) && mem_ack;
   assign rf_we       = cur == S_WB;
   assign halted      = cur == S_HALT;
   assign pc_we       = ((cur == S_EXEC) && !is_mem && !cu_regwrite) ||
                        ((cur == S_MEM) && mem_ack && !cu_resultsrc) ||
                        (cur == S_WB);

`ifdef PERF_CNT_EN
   perf_counters #(.DATA_WIDTH(DATA_WIDTH)) u_perf (
      .clk       (clk),
      .rst       (rst),
      .active    ((cur != S_IDLE) && (cur != S_HALT)),
      .retire    (pc_we),
      .cycle_cnt (cycle_cnt),
      .instret   (instret)
   );
`endif
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: builds an expected per-cycle timeline for each instruction from the
// phase rules, drives op/decoder/ack/run from it and checks every cycle of the DUT.
module tb_mc_sequencer;
   localparam int DW = 32;
   localparam logic [6:0] RND = 7'h7f;
   localparam logic [6:0] ALU_OPS [4] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111};
   localparam logic [6:0] J_OPS   [2] = '{7'b1101111, 7'b1100111};
   localparam logic [6:0] LEGAL  [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                          7'b0010111, 7'b1110011};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0, cu_regwrite = 1'b0, cu_memwrite = 1'b0, cu_resultsrc = 1'b0, mem_ack = 1'b0;
   logic [6:0] op = '0;
   logic mem_req, mem_we, mem_isfetch, ir_we, pc_we, rf_we, halted;
   logic [2:0] state;
   logic [DW-1:0] cycle_cnt, instret;

   typedef struct {
      logic [2:0] st;
      logic       ack;
      logic       run;
      logic [6:0] op;
      logic       rw, mw, rs;
      logic [6:0] strb;
   } cyc_t;

   cyc_t q[$];
   int vectors = 0, miscompares = 0;
   logic prev_run = 1'b0;
   logic [6:0] c_op;
   logic c_rw, c_mw, c_rs;
   logic [DW-1:0] m_cyc = '0, m_ret = '0;

   mc_sequencer #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .run(run), .op(op),
      .cu_regwrite(cu_regwrite), .cu_memwrite(cu_memwrite), .cu_resultsrc(cu_resultsrc),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_isfetch(mem_isfetch),
      .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .halted(halted), .state(state)
`ifdef PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
   );

`ifndef PERF_CNT_EN
   assign cycle_cnt = '0;
   assign instret   = '0;
`endif

   always #5 clk = ~clk;

   function automatic logic is_legal(input logic [6:0] o);
      foreach (LEGAL[i]) if (LEGAL[i] == o) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // strb = {mem_req, mem_isfetch, mem_we, ir_we, pc_we, rf_we, halted}
   task automatic push(input logic [2:0] st, input logic ack, input logic rn, input logic [6:0] strb);
      cyc_t e;
      e.st = st; e.ack = ack; e.run = rn; e.op = c_op;
      e.rw = c_rw; e.mw = c_mw; e.rs = c_rs; e.strb = strb;
      q.push_back(e);
   endtask

   // kinds: 0 alu/lui/auipc, 1 jal/jalr, 2 load, 3 store, 4 branch, 5 ecall, 6 illegal
   task automatic plan(input int k, input logic [6:0] fo, input int wf, input int wm, input logic last_run);
      c_rw = 1'b0; c_mw = 1'b0; c_rs = 1'b0;
      case (k)
         0: begin c_op = ALU_OPS[$urandom_range(0, 3)]; c_rw = 1'b1; end
         1: begin c_op = J_OPS[$urandom_range(0, 1)]; c_rw = 1'b1; end
         2: begin c_op = 7'b0000011; c_rs = 1'b1; end
         3: begin c_op = 7'b0100011; c_mw = 1'b1; end
         4: c_op = 7'b1100011;
         5: c_op = 7'b1110011;
         default: begin
            c_op = 7'($urandom());
            if (is_legal(c_op)) c_op = 7'h00;
            c_rw = rb(); c_mw = rb(); c_rs = rb();
         end
      endcase
      if (fo != RND) c_op = fo;
      if (!prev_run) begin
         repeat ($urandom_range(0, 2)) push(3'd0, rb(), 1'b0, 7'b0000000);
         push(3'd0, rb(), 1'b1, 7'b0000000);
      end
      repeat (wf) push(3'd1, 1'b0, rb(), 7'b1100000);
      push(3'd1, 1'b1, rb(), 7'b1101000);
      push(3'd2, rb(), rb(), 7'b0000000);
      if (k >= 5) begin
         repeat (3) push(3'd6, rb(), rb(), 7'b0000001);
         prev_run = 1'b0;
      end else if (k == 4) begin
         push(3'd3, rb(), last_run, 7'b0000100);
         prev_run = last_run;
      end else begin
         push(3'd3, rb(), rb(), 7'b0000000);
         if (k == 2 || k == 3) begin
            repeat (wm) push(3'd4, 1'b0, rb(), {2'b10, c_mw, 4'b0000});
            if (k == 3) push(3'd4, 1'b1, last_run, 7'b1010100);
            else        push(3'd4, 1'b1, rb(), 7'b1000000);
         end
         if (k != 3) push(3'd5, rb(), last_run, 7'b0000110);
         prev_run = last_run;
      end
   endtask

   task automatic exec_plan(input logic stop_in_mem);
      cyc_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         op = e.op; cu_regwrite = e.rw; cu_memwrite = e.mw; cu_resultsrc = e.rs;
         mem_ack = e.ack; run = e.run;
         #4;
         vectors++;
         assert ({state, mem_req, mem_isfetch, mem_we, ir_we, pc_we, rf_we, halted} === {e.st, e.strb})
         else begin
            miscompares++;
            $error("FAIL seq v=%0d op=%b observed st=%0d strb=%b expected st=%0d strb=%b", vectors, e.op,
                   state, {mem_req, mem_isfetch, mem_we, ir_we, pc_we, rf_we, halted}, e.st, e.strb);
         end
`ifdef PERF_CNT_EN
         vectors++;
         assert ({cycle_cnt, instret} === {m_cyc, m_ret})
         else begin
            miscompares++;
            $error("FAIL perf v=%0d observed cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                   vectors, cycle_cnt, instret, m_cyc, m_ret);
         end
`endif
         m_cyc += DW'(e.st != 3'd0 && e.st != 3'd6);
         m_ret += DW'(e.strb[2]);
         @(posedge clk); #1;
         if (stop_in_mem && e.st == 3'd4) break;
      end
      q.delete();
   endtask

   task automatic check_zero(input string tag);
      vectors++;
      assert ({state, mem_req, mem_isfetch, mem_we, ir_we, pc_we, rf_we, halted, cycle_cnt, instret} === '0)
      else begin
         miscompares++;
         $error("FAIL %s observed st=%0d strb=%b cyc=%0d ret=%0d expected all zero", tag, state,
                {mem_req, mem_isfetch, mem_we, ir_we, pc_we, rf_we, halted}, cycle_cnt, instret);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; mem_ack = 1'b0;
      @(posedge clk); #1;
      check_zero("reset");
      rst = 1'b0;
      m_cyc = '0; m_ret = '0; prev_run = 1'b0;
   endtask

   initial begin
      do_reset();
      plan(0, 7'b0110011, 0, 0, 1'b1);
      plan(2, 7'b0000011, 0, 3, 1'b1);
      plan(3, 7'b0100011, 1, 0, 1'b1);
      plan(4, 7'b1100011, 0, 0, 1'b0);
      exec_plan(1'b0);
      repeat (150) plan($urandom_range(0, 4), RND, $urandom_range(0, 2), $urandom_range(0, 3),
                        $urandom_range(0, 3) != 0);
      exec_plan(1'b0);
      plan(2, 7'b0000011, 0, 5, 1'b1);
      exec_plan(1'b1);
      mem_ack = 1'b0;
      #2;
      vectors++;
      assert ({mem_req, state} === {1'b1, 3'd4})
      else begin
         miscompares++;
         $error("FAIL pre_rst observed req=%b st=%0d expected req=1 st=4", mem_req, state);
      end
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      m_cyc = '0; m_ret = '0; prev_run = 1'b0;
      plan(5, 7'b1110011, 0, 0, 1'b1);
      exec_plan(1'b0);
      do_reset();
      plan(6, 7'h00, 1, 0, 1'b1);
      exec_plan(1'b0);
      do_reset();
      repeat (4) begin
         plan($urandom_range(0, 4), RND, $urandom_range(0, 1), $urandom_range(0, 2), 1'b1);
         plan(6, RND, $urandom_range(0, 2), 0, 1'b1);
         exec_plan(1'b0);
         do_reset();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
